// File: rtl/vram_slot_responder_if.sv
// Memory-side word port of the VRAM slot responder (req/ack, 16-bit data).
// Also provides the PRAM_SIZE encodings shared by responder and consumers.
`ifndef MEMORY_WIDTH_8
`define MEMORY_WIDTH_8  2'b00
`endif
`ifndef MEMORY_WIDTH_16
`define MEMORY_WIDTH_16 2'b01
`endif
`ifndef MEMORY_WIDTH_32
`define MEMORY_WIDTH_32 2'b10
`endif

interface vram_slot_responder_if #(
  parameter int unsigned MEM_AW = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [1:0]        mem_be;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/vram_slot_responder.sv
// VDP VRAM slot responder: one arbiter access per dot cycle run against a req/ack word memory.
// VRAM_WIDE_ACCESS_EN builds the two-word 32-bit sequence; otherwise 32-bit requests act as 16-bit.
`ifndef MEMORY_WIDTH_8
`define MEMORY_WIDTH_8  2'b00
`endif
`ifndef MEMORY_WIDTH_16
`define MEMORY_WIDTH_16 2'b01
`endif
`ifndef MEMORY_WIDTH_32
`define MEMORY_WIDTH_32 2'b10
`endif

module vram_slot_responder #(
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned OVR_W  = 8
) (
  input  logic                  CLK21M,
  input  logic                  RESET,
  input  logic [1:0]            DOTSTATE,
  input  logic [16:0]           IRAMADR,
  input  logic [7:0]            PRAMDBO,
  input  logic [31:0]           PRAMDBO_32,
  input  logic                  PRAMWE_N,
  input  logic [1:0]            PRAM_SIZE,
  output logic [15:0]           PRAMDBI,
  output logic [31:0]           PRAMDBI_32,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  slot_overrun,
  output logic [OVR_W-1:0]      overrun_cnt,
  vram_slot_responder_if.master mem
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
`ifdef VRAM_WIDE_ACCESS_EN
    ST_ISSUE1,
    ST_WAIT1,
`endif
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic        sample;
  logic        req_is8;
  logic        req_is32;
  logic [15:0] req_waddr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata0;
  logic        hi_phase;
  logic        mem_req_c;

  logic [15:0] addr_q;
  logic        we_q;
  logic [1:0]  be_q;
  logic [15:0] wdata0_q;
  logic [15:0] word0_q;
`ifdef VRAM_WIDE_ACCESS_EN
  logic        is32_q;
  logic [15:0] wdata1_q;
  logic [15:0] word1_q;
`else
  logic        unused_wdata_hi;
  assign unused_wdata_hi = ^PRAMDBO_32[31:16];
`endif

  assign sample  = (DOTSTATE == 2'b11);
  assign req_is8 = (PRAM_SIZE == `MEMORY_WIDTH_8);
`ifdef VRAM_WIDE_ACCESS_EN
  assign req_is32 = (PRAM_SIZE == `MEMORY_WIDTH_32);
  assign hi_phase = (state_q == ST_ISSUE1);
`else
  assign req_is32 = 1'b0;
  assign hi_phase = 1'b0;
`endif

  assign req_waddr  = req_is32 ? {IRAMADR[16:2], 1'b0} : IRAMADR[16:1];
  assign req_be     = (!PRAMWE_N && req_is8) ? (IRAMADR[0] ? 2'b10 : 2'b01) : 2'b11;
  assign req_wdata0 = req_is8 ? {PRAMDBO, PRAMDBO} : PRAMDBO_32[15:0];

  assign busy          = (state_q != ST_IDLE);
  assign mem.mem_req   = mem_req_c;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = MEM_AW'(addr_q | {15'b0, hi_phase});
`ifdef VRAM_WIDE_ACCESS_EN
  assign mem.mem_wdata = hi_phase ? wdata1_q : wdata0_q;
`else
  assign mem.mem_wdata = wdata0_q;
`endif

  always_ff @(posedge CLK21M) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    case (state_q)
      ST_IDLE:   if (sample) state_d = ST_ISSUE0;
      ST_ISSUE0: begin
        mem_req_c = 1'b1;
        state_d   = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (mem.mem_ack) begin
`ifdef VRAM_WIDE_ACCESS_EN
          state_d = is32_q ? ST_ISSUE1 : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef VRAM_WIDE_ACCESS_EN
      ST_ISSUE1: begin
        mem_req_c = 1'b1;
        state_d   = ST_WAIT1;
      end
      ST_WAIT1:  if (mem.mem_ack) state_d = ST_DONE;
`endif
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch, read capture and result publication; a DONE-cycle sample
  // sees a non-IDLE state and is counted as an overrun.
  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata0_q     <= '0;
      word0_q      <= '0;
`ifdef VRAM_WIDE_ACCESS_EN
      is32_q       <= 1'b0;
      wdata1_q     <= '0;
      word1_q      <= '0;
`endif
      PRAMDBI      <= '0;
      PRAMDBI_32   <= '0;
      rd_valid     <= 1'b0;
      slot_overrun <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      rd_valid     <= 1'b0;
      slot_overrun <= 1'b0;

      if (sample) begin
        if (state_q == ST_IDLE) begin
          addr_q   <= req_waddr;
          we_q     <= ~PRAMWE_N;
          be_q     <= req_be;
          wdata0_q <= req_wdata0;
`ifdef VRAM_WIDE_ACCESS_EN
          is32_q   <= req_is32;
          wdata1_q <= PRAMDBO_32[31:16];
`endif
        end else begin
          slot_overrun <= 1'b1;
          if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
      end

      if (state_q == ST_WAIT0 && mem.mem_ack) word0_q <= mem.mem_rdata;
`ifdef VRAM_WIDE_ACCESS_EN
      if (state_q == ST_WAIT1 && mem.mem_ack) word1_q <= mem.mem_rdata;
`endif

      if (state_q == ST_DONE && !we_q) begin
        PRAMDBI  <= word0_q;
        rd_valid <= 1'b1;
`ifdef VRAM_WIDE_ACCESS_EN
        PRAMDBI_32 <= is32_q ? {word1_q, word0_q} : {16'h0000, word0_q};
`else
        PRAMDBI_32 <= {16'h0000, word0_q};
`endif
      end
    end
  end

endmodule

// File: tb/tb_vram_slot_responder.sv
// Directed bench for vram_slot_responder with a variable-latency req/ack memory model.
`ifndef MEMORY_WIDTH_8
`define MEMORY_WIDTH_8  2'b00
`endif
`ifndef MEMORY_WIDTH_16
`define MEMORY_WIDTH_16 2'b01
`endif
`ifndef MEMORY_WIDTH_32
`define MEMORY_WIDTH_32 2'b10
`endif

module tb_vram_slot_responder;
  logic        CLK21M = 1'b0;
  logic        RESET  = 1'b1;
  logic [1:0]  DOTSTATE = 2'b00;
  logic [16:0] IRAMADR = '0;
  logic [7:0]  PRAMDBO = '0;
  logic [31:0] PRAMDBO_32 = '0;
  logic        PRAMWE_N = 1'b1;
  logic [1:0]  PRAM_SIZE = `MEMORY_WIDTH_16;
  logic [15:0] PRAMDBI;
  logic [31:0] PRAMDBI_32;
  logic        rd_valid, busy, slot_overrun;
  logic [1:0]  overrun_cnt;

  always #5 CLK21M = ~CLK21M;

  vram_slot_responder_if #(.MEM_AW(16)) mem_if ();

  vram_slot_responder #(.MEM_AW(16), .OVR_W(2)) dut (
    .CLK21M(CLK21M), .RESET(RESET), .DOTSTATE(DOTSTATE), .IRAMADR(IRAMADR),
    .PRAMDBO(PRAMDBO), .PRAMDBO_32(PRAMDBO_32), .PRAMWE_N(PRAMWE_N), .PRAM_SIZE(PRAM_SIZE),
    .PRAMDBI(PRAMDBI), .PRAMDBI_32(PRAMDBI_32), .rd_valid(rd_valid), .busy(busy),
    .slot_overrun(slot_overrun), .overrun_cnt(overrun_cnt), .mem(mem_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: ack arrives ack_dly cycles after the request cycle.
  int          ack_dly = 1;
  int          pend = 0;
  logic [15:0] pend_data = '0;
  logic [15:0] rd_q[$];
  logic        m_ack = 1'b0;
  logic [15:0] m_rdata = '0;
  int          req_cnt = 0;
  logic [15:0] req_addr_log[8];
  logic [15:0] last_addr = '0, last_wdata = '0;
  logic [1:0]  last_be = '0;
  logic        last_we = 1'b0;

  assign mem_if.mem_ack   = m_ack;
  assign mem_if.mem_rdata = m_rdata;

  always @(posedge CLK21M) begin
    m_ack <= 1'b0;
    if (mem_if.mem_req) begin
      if (rd_q.size() > 0) pend_data = rd_q.pop_front();
      else                 pend_data = 16'hDEAD;
      if (req_cnt < 8) req_addr_log[req_cnt] <= mem_if.mem_addr;
      req_cnt    <= req_cnt + 1;
      last_addr  <= mem_if.mem_addr;
      last_be    <= mem_if.mem_be;
      last_we    <= mem_if.mem_we;
      last_wdata <= mem_if.mem_wdata;
      if (ack_dly == 1) begin
        m_ack   <= 1'b1;
        m_rdata <= pend_data;
        pend    <= 0;
      end else begin
        pend <= ack_dly - 1;
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        m_ack   <= 1'b1;
        m_rdata <= pend_data;
      end
    end
  end

  int rdv_cnt = 0;
  int ovr_cnt = 0;
  always @(negedge CLK21M) begin
    if (rd_valid)     rdv_cnt++;
    if (slot_overrun) ovr_cnt++;
  end

  task automatic slot(input logic [16:0] a, input logic we_n, input logic [1:0] sz,
                      input logic [7:0] d8, input logic [31:0] d32);
    @(negedge CLK21M);
    IRAMADR = a; PRAMWE_N = we_n; PRAM_SIZE = sz; PRAMDBO = d8; PRAMDBO_32 = d32;
    DOTSTATE = 2'b11;
    @(negedge CLK21M);
    DOTSTATE = 2'b00;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK21M);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("timeout_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge CLK21M);
  endtask

  int req0, rdv0, ovr0;

  task automatic snap();
    req0 = req_cnt; rdv0 = rdv_cnt; ovr0 = ovr_cnt;
  endtask

  initial begin
    repeat (3) @(negedge CLK21M);
    check("rst_pramdbi",   {16'h0, PRAMDBI}, 32'h0);
    check("rst_pramdbi32", PRAMDBI_32, 32'h0);
    check("rst_flags",     {28'h0, rd_valid, busy, slot_overrun, mem_if.mem_req}, 32'h0);
    check("rst_ovr_cnt",   {30'h0, overrun_cnt}, 32'h0);
    check("rst_mem_bus",   {mem_if.mem_we, mem_if.mem_be, mem_if.mem_addr}, 32'h0);
    check("rst_mem_wdata", {16'h0, mem_if.mem_wdata}, 32'h0);
    RESET = 1'b0;

    // T1: 16-bit read
    ack_dly = 1; rd_q.push_back(16'hBEEF); snap();
    slot(17'h00124, 1'b1, `MEMORY_WIDTH_16, 8'h00, 32'h0);
    wait_idle();
    check("t1_req_cnt",  req_cnt - req0, 1);
    check("t1_addr_be",  {last_we, last_be, last_addr}, {15'h0, 1'b0, 2'b11, 16'h0092});
    check("t1_rd_valid", rdv_cnt - rdv0, 1);
    check("t1_pramdbi",  {16'h0, PRAMDBI}, 32'h0000BEEF);
    check("t1_dbi32",    PRAMDBI_32, 32'h0000BEEF);

    // T2: 8-bit write to the odd byte
    snap();
    slot(17'h00125, 1'b0, `MEMORY_WIDTH_8, 8'h5A, 32'h0);
    wait_idle();
    check("t2_req_cnt",  req_cnt - req0, 1);
    check("t2_addr_be",  {last_we, last_be, last_addr}, {15'h0, 1'b1, 2'b10, 16'h0092});
    check("t2_wdata",    {16'h0, last_wdata}, 32'h00005A5A);
    check("t2_no_rdv",   rdv_cnt - rdv0, 0);
    check("t2_dbi_kept", {16'h0, PRAMDBI}, 32'h0000BEEF);

    // 8-bit write to the even byte, then 16-bit write with address LSB set
    slot(17'h00040, 1'b0, `MEMORY_WIDTH_8, 8'hC3, 32'h0);
    wait_idle();
    check("w8e_addr_be", {last_we, last_be, last_addr}, {15'h0, 1'b1, 2'b01, 16'h0020});
    slot(17'h00201, 1'b0, `MEMORY_WIDTH_16, 8'h00, 32'hCAFE1234);
    wait_idle();
    check("w16_addr_be", {last_we, last_be, last_addr}, {15'h0, 1'b1, 2'b11, 16'h0100});
    check("w16_wdata",   {16'h0, last_wdata}, 32'h00001234);

`ifdef VRAM_WIDE_ACCESS_EN
    // T3: 32-bit read at the top of memory
    ack_dly = 1; rd_q.push_back(16'h1111); rd_q.push_back(16'h2222); snap();
    slot(17'h1FFFC, 1'b1, `MEMORY_WIDTH_32, 8'h00, 32'h0);
    wait_idle();
    check("t3_req_cnt", req_cnt - req0, 2);
    check("t3_addr0",   {16'h0, req_addr_log[req0 % 8]}, 32'h0000FFFE);
    check("t3_addr1",   {16'h0, req_addr_log[(req0 + 1) % 8]}, 32'h0000FFFF);
    check("t3_dbi32",   PRAMDBI_32, 32'h22221111);
    check("t3_pramdbi", {16'h0, PRAMDBI}, 32'h00001111);
    check("t3_rdv",     rdv_cnt - rdv0, 1);
`else
    // T6: 32-bit read degrades to one 16-bit access
    ack_dly = 1; rd_q.push_back(16'h7777); snap();
    slot(17'h00006, 1'b1, `MEMORY_WIDTH_32, 8'h00, 32'h0);
    wait_idle();
    check("t6_req_cnt", req_cnt - req0, 1);
    check("t6_addr",    {16'h0, last_addr}, 32'h00000003);
    check("t6_dbi32",   PRAMDBI_32, 32'h00007777);
    check("t6_rdv",     rdv_cnt - rdv0, 1);
`endif

    // T4: overrun with slow memory, then saturation at 2 bits
    ack_dly = 6; rd_q.push_back(16'h4444); snap();
    slot(17'h00000, 1'b1, `MEMORY_WIDTH_16, 8'h00, 32'h0);
    slot(17'h00002, 1'b1, `MEMORY_WIDTH_16, 8'h00, 32'h0);
    wait_idle();
    check("t4_ovr_pulse", ovr_cnt - ovr0, 1);
    check("t4_ovr_cnt",   {30'h0, overrun_cnt}, 32'h1);
    check("t4_req_cnt",   req_cnt - req0, 1);
    check("t4_pramdbi",   {16'h0, PRAMDBI}, 32'h00004444);
    ack_dly = 20; rd_q.push_back(16'h4545); snap();
    slot(17'h00004, 1'b1, `MEMORY_WIDTH_16, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) slot(17'h00008, 1'b1, `MEMORY_WIDTH_16, 8'h00, 32'h0);
    wait_idle();
    check("t4_ovr5",    ovr_cnt - ovr0, 5);
    check("t4_sat_cnt", {30'h0, overrun_cnt}, 32'h3);
    check("t4_req2",    req_cnt - req0, 1);

    // T5: reset while waiting for ack; the late ack must be ignored
    ack_dly = 4; rd_q.push_back(16'h5555); snap();
    slot(17'h00010, 1'b1, `MEMORY_WIDTH_16, 8'h00, 32'h0);
    @(negedge CLK21M);
    check("t5_busy_wait", {31'h0, busy}, 32'h1);
    RESET = 1'b1;
    repeat (2) @(negedge CLK21M);
    RESET = 1'b0;
    repeat (6) @(negedge CLK21M);
    check("t5_no_rdv",   rdv_cnt - rdv0, 0);
    check("t5_idle",     {30'h0, busy, rd_valid}, 32'h0);
    check("t5_pramdbi",  {16'h0, PRAMDBI}, 32'h0);
    check("t5_dbi32",    PRAMDBI_32, 32'h0);
    check("t5_ovr_cnt",  {30'h0, overrun_cnt}, 32'h0);
    check("t5_req_cnt",  req_cnt - req0, 1);
    ack_dly = 1; rd_q.push_back(16'h6666); snap();
    slot(17'h00010, 1'b1, `MEMORY_WIDTH_16, 8'h00, 32'h0);
    wait_idle();
    check("t5_next_addr", {16'h0, last_addr}, 32'h00000008);
    check("t5_next_dbi",  {16'h0, PRAMDBI}, 32'h00006666);
    check("t5_next_rdv",  rdv_cnt - rdv0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
